// File: rtl/vga_pattern_core_if.sv
// Pixel-side bundle of vga_pattern_core: strobe/pattern controls in, timed video out.
// master = the pattern core, slave = whatever consumes the video (pins, bench).
interface vga_pattern_core_if #(
    parameter int COLOR_BITS = 4,
    parameter int X_W        = 10,
    parameter int Y_W        = 10
);
    logic                      pix_en;
    logic [1:0]                mode_sel;
    logic [3*COLOR_BITS-1:0]   fg_color;
    logic                      hsync;
    logic                      vsync;
    logic [COLOR_BITS-1:0]     red;
    logic [COLOR_BITS-1:0]     green;
    logic [COLOR_BITS-1:0]     blue;
    logic                      video_active;
    logic [X_W-1:0]            x_loc;
    logic [Y_W-1:0]            y_loc;
    logic                      frame_start;

    modport master (
        input  pix_en, mode_sel, fg_color,
        output hsync, vsync, red, green, blue, video_active, x_loc, y_loc, frame_start
    );

    modport slave (
        output pix_en, mode_sel, fg_color,
        input  hsync, vsync, red, green, blue, video_active, x_loc, y_loc, frame_start
    );
endinterface

// File: rtl/vga_pattern_core.sv
// VGA timing + test patterns (solid/bars/checker/ramp); VGA_PATTERN_BORDER_EN adds a white edge.
// Latency: one pix_en tick from counter state to registered outputs; frame_start is a 1-clk pulse.
// No backpressure: pix_en=0 freezes counters and outputs, rst dominates pix_en.
module vga_pattern_core #(
    parameter int   H_PIXELS      = 640,
    parameter int   H_FRONT_PORCH = 16,
    parameter int   H_SYNC        = 96,
    parameter int   H_BACK_PORCH  = 48,
    parameter int   V_PIXELS      = 480,
    parameter int   V_FRONT_PORCH = 10,
    parameter int   V_SYNC        = 2,
    parameter int   V_BACK_PORCH  = 33,
    parameter logic SYNC_ACTIVE   = 1'b0,
    parameter int   COLOR_BITS    = 4,
    parameter int   CHECK_LOG2    = 5
) (
    input  logic               clk,
    input  logic               rst,
    vga_pattern_core_if.master vid
);
    localparam int TOTAL_W  = H_PIXELS + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
    localparam int TOTAL_H  = V_PIXELS + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;
    localparam int X_W      = $clog2(TOTAL_W + 1);
    localparam int Y_W      = $clog2(TOTAL_H + 1);
    localparam int HS_START = H_PIXELS + H_FRONT_PORCH;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_PIXELS + V_FRONT_PORCH;
    localparam int VS_END   = VS_START + V_SYNC;
    // Narrow screens have no room for bars; BAR_END=0 then blacks out every pixel.
    localparam int BAR_W    = (H_PIXELS >= 8) ? (H_PIXELS / 8) : 1;
    localparam int BAR_END  = 8 * (H_PIXELS / 8);

    logic [X_W-1:0]        h_q, h_d;
    logic [Y_W-1:0]        v_q, v_d;
    logic [1:0]            mode_q, mode_d;
    logic                  hsync_q, hsync_d;
    logic                  vsync_q, vsync_d;
    logic                  active_q, active_d;
    logic [COLOR_BITS-1:0] red_q, red_d;
    logic [COLOR_BITS-1:0] green_q, green_d;
    logic [COLOR_BITS-1:0] blue_q, blue_d;
    logic [X_W-1:0]        x_q;
    logic [Y_W-1:0]        y_q;
    logic                  frame_start_q, frame_start_d;

    logic                  h_last, v_last;
    logic [31:0]           hx, vx;
    logic [2:0]            bar_idx;
    logic [COLOR_BITS-1:0] grey;
    logic                  chk_odd;

    always_comb begin
        h_last   = (h_q == X_W'(TOTAL_W - 1));
        v_last   = (v_q == Y_W'(TOTAL_H - 1));
        hx       = 32'(h_q);
        vx       = 32'(v_q);
        bar_idx  = 3'(hx / 32'(BAR_W));
        grey     = COLOR_BITS'((hx << COLOR_BITS) / 32'(H_PIXELS));
        chk_odd  = (((hx ^ vx) >> CHECK_LOG2) & 32'd1) != 32'd0;

        h_d = h_q + X_W'(1);
        v_d = v_q;
        if (h_last) begin
            h_d = '0;
            v_d = v_last ? '0 : v_q + Y_W'(1);
        end
        mode_d = (h_last && v_last) ? vid.mode_sel : mode_q;

        active_d = (h_q < X_W'(H_PIXELS)) && (v_q < Y_W'(V_PIXELS));
        hsync_d  = ((h_q >= X_W'(HS_START)) && (h_q < X_W'(HS_END))) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d  = ((v_q >= Y_W'(VS_START)) && (v_q < Y_W'(VS_END))) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        frame_start_d = vid.pix_en && (h_q == '0) && (v_q == '0);

        {red_d, green_d, blue_d} = '0;
        case (mode_q)
            2'd0: {red_d, green_d, blue_d} = vid.fg_color;
            2'd1: begin
                // Bar index bits map straight to inverted {g,r,b}: W,Y,C,G,M,R,B,K.
                if (hx < 32'(BAR_END)) begin
                    red_d   = {COLOR_BITS{~bar_idx[1]}};
                    green_d = {COLOR_BITS{~bar_idx[2]}};
                    blue_d  = {COLOR_BITS{~bar_idx[0]}};
                end
            end
            2'd2: if (!chk_odd) {red_d, green_d, blue_d} = vid.fg_color;
            default: begin
                red_d   = grey;
                green_d = grey;
                blue_d  = grey;
            end
        endcase

`ifdef VGA_PATTERN_BORDER_EN
        if ((h_q == '0) || (h_q == X_W'(H_PIXELS - 1)) ||
            (v_q == '0) || (v_q == Y_W'(V_PIXELS - 1))) begin
            {red_d, green_d, blue_d} = '1;
        end
`endif

        if (!active_d) {red_d, green_d, blue_d} = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q           <= '0;
            v_q           <= '0;
            mode_q        <= vid.mode_sel;
            hsync_q       <= ~SYNC_ACTIVE;
            vsync_q       <= ~SYNC_ACTIVE;
            active_q      <= 1'b0;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            x_q           <= '0;
            y_q           <= '0;
            frame_start_q <= 1'b0;
        end else begin
            // The pulse clears on the next clk regardless of pix_en.
            frame_start_q <= frame_start_d;
            if (vid.pix_en) begin
                h_q      <= h_d;
                v_q      <= v_d;
                mode_q   <= mode_d;
                hsync_q  <= hsync_d;
                vsync_q  <= vsync_d;
                active_q <= active_d;
                red_q    <= red_d;
                green_q  <= green_d;
                blue_q   <= blue_d;
                x_q      <= h_q;
                y_q      <= v_q;
            end
        end
    end

    assign vid.hsync        = hsync_q;
    assign vid.vsync        = vsync_q;
    assign vid.video_active = active_q;
    assign vid.red          = red_q;
    assign vid.green        = green_q;
    assign vid.blue         = blue_q;
    assign vid.x_loc        = x_q;
    assign vid.y_loc        = y_q;
    assign vid.frame_start  = frame_start_q;
endmodule

// File: doc/vga_pattern_core.md
# vga_pattern_core

Parametrised VGA timing and test-pattern engine: one block that generates hsync/vsync, the active-video window and registered RGB pixel data for any resolution and colour depth. It runs in the system clock domain and advances one pixel per `pix_en` strobe, so 640x480@60 runs from 100 MHz with a /4 strobe. It drives the board VGA pins directly and replaces the fixed-colour output with runtime-selectable patterns.

## Interface
- `H_PIXELS`, 640, active pixels per line
- `H_FRONT_PORCH`, 16, horizontal front porch, in pixels
- `H_SYNC`, 96, horizontal sync width, in pixels
- `H_BACK_PORCH`, 48, horizontal back porch, in pixels
- `V_PIXELS`, 480, active lines per frame
- `V_FRONT_PORCH`, 10, vertical front porch, in lines
- `V_SYNC`, 2, vertical sync width, in lines
- `V_BACK_PORCH`, 33, vertical back porch, in lines
- `SYNC_ACTIVE`, 0, level of hsync/vsync during the sync pulse
- `COLOR_BITS`, 4, bits per colour channel
- `CHECK_LOG2`, 5, log2 of the checkerboard square size, in pixels
- Derived: `TOTAL_W` is the sum of the four H values; `TOTAL_H` is the sum of the four V values.
- Derived counter widths: `$clog2(TOTAL_W+1)` for x and `$clog2(TOTAL_H+1)` for y.
- `clk` in 1 system clock; all logic on the rising edge
- `rst` in 1 synchronous, active-high reset
- `pix_en` in 1 pixel strobe; the pixel pipeline advances only on cycles where it is 1
- `mode_sel` in 2 pattern select: 0 solid, 1 colour bars, 2 checkerboard, 3 grey ramp
- `fg_color` in 3*COLOR_BITS solid/checker foreground colour, packed {r,g,b}
- `hsync` out 1 horizontal sync
- `vsync` out 1 vertical sync
- `red`, `green`, `blue` out COLOR_BITS each, pixel colour
- `video_active` out 1 high while the output pixel is inside the active window
- `x_loc` out x width, x coordinate of the current output pixel
- `y_loc` out y width, y coordinate of the current output pixel
- `frame_start` out 1 one-`clk` pulse marking pixel (0,0)

## Operation
- Counters `h` (0..TOTAL_W-1) and `v` (0..TOTAL_H-1) advance once per `pix_en` tick.
- `h` wraps to 0 at TOTAL_W-1, and `v` increments on that same tick. `v` wraps to 0 at TOTAL_H-1 together with `h`.
- A pixel is active when `h<H_PIXELS` and `v<V_PIXELS`.
- Horizontal sync is asserted (at level `SYNC_ACTIVE`) for `H_PIXELS+H_FRONT_PORCH <= h < H_PIXELS+H_FRONT_PORCH+H_SYNC`.
- Vertical sync is asserted for the equivalent range of `v`. Outside these ranges each sync is at `!SYNC_ACTIVE`.
- Patterns use `mode_q`, a registered copy of `mode_sel`:
  - Mode 0 (solid): output is `fg_color`.
  - Mode 1 (colour bars): 8 bars of width `H_PIXELS/8`. Order: white, yellow, cyan, green, magenta, red, blue, black. Channels are all-ones or zero. Pixels with `h >= 8*(H_PIXELS/8)` are black.
  - Mode 2 (checkerboard): `fg_color` where `h[CHECK_LOG2]^v[CHECK_LOG2]` is 0, otherwise black.
  - Mode 3 (grey ramp): all channels = `(h*2^COLOR_BITS)/H_PIXELS`, truncated to COLOR_BITS bits. Range is 0 at h=0 up to all-ones.
- Outside the active window, RGB is forced to 0 regardless of mode.
- `mode_q` loads `mode_sel` only on the tick where h=TOTAL_W-1 and v=TOTAL_H-1, so patterns never change mid-frame. During `rst`, `mode_q` loads `mode_sel`.
- `fg_color` is sampled live every tick; it is not frame-latched.

## Timing
- All outputs are registered and update only on `pix_en` ticks; they hold their values between ticks.
- Latency: on each tick, the outputs present the pixel whose counters were current before that tick. hsync, vsync, RGB, `video_active`, `x_loc` and `y_loc` are mutually aligned.
- `frame_start` is high for exactly one `clk` cycle: the cycle immediately after the tick that outputs (0,0).
- `pix_en` held at 1 is legal and gives one pixel per clock. `pix_en`=0 freezes all state.
- Reset values:
  - h and v counters 0
  - `hsync`/`vsync` = `!SYNC_ACTIVE`
  - RGB 0, `video_active` 0, `x_loc`/`y_loc` 0, `frame_start` 0
- `rst` dominates `pix_en`. Asserting `rst` mid-frame applies reset values on the next edge. The first tick after reset releases outputs pixel (0,0) and pulses `frame_start`.

## Configuration
- `VGA_PATTERN_BORDER_EN` defined:
  - Active pixels with h=0, h=H_PIXELS-1, v=0 or v=V_PIXELS-1 are forced to all-ones (white) in every mode.
  - Used to check monitor overscan.
- Undefined: no border logic is compiled; the pattern is unmodified at the edges.

## Test plan
- Use H=16/2/2/4, V=8/1/1/2, `pix_en`=1, SYNC_ACTIVE=0.
  - Expect TOTAL_W=24 and TOTAL_H=12.
  - hsync is low for exactly 2 ticks per line, starting at output x=18.
  - vsync is low for 24 ticks starting at y=9; period is 288 ticks.
- `mode_sel`=1, H_PIXELS=16 -> x=0..1 white (all-ones) and x=14..15 black. x=4..5 RGB = 0,F,F (4-bit).
- Toggle `mode_sel` 0->3 mid-frame -> output stays solid `fg_color` until the next `frame_start`, then becomes the ramp: x=0 -> 0, x=15 -> 0xF.
- `pix_en` at 1-in-4 cadence -> outputs change only on strobe cycles; `frame_start` is high for 1 `clk` cycle per 1152 clocks.
- Assert `rst` for 1 cycle at x=10, y=3:
  - Next cycle: hsync/vsync high, RGB 0, `video_active` 0.
  - First tick after release: (0,0) with `frame_start`=1.
- With `VGA_PATTERN_BORDER_EN`, mode 2 and `fg_color`=0 -> x=0, x=15, y=0 and y=7 are all white; interior pixels are black.
